mem_responder: RTL and testbench

- Memory-side end of the cache controller <-> memory interface.
- Accepts line requests carrying the fields of mem_req_type (addr, data, rw, valid) and returns responses carrying the fields of mem_data_type (data, ready) after a fixed latency.
- Backed by an internal array of 256-bit lines. Serves as the main-memory model behind the cache controller in simulation and synthesis.

---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Fixed-latency main-memory model: accepts one line request, answers DELAY cycles later with a one-cycle mem_ready.
// Optional MEM_PROTO_CHECK_EN builds a sticky checker for request inputs that change while a request is in flight.
module mem_responder #(
  parameter int DELAY    = 100,
  parameter int DEPTH    = 1024,
  parameter int LINE_LSB = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_req_addr,
  input  logic [255:0] mem_req_data,
  input  logic         mem_req_rw,
  input  logic         mem_req_valid,
  output logic [255:0] mem_data,
  output logic         mem_ready,
  output logic         proto_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [255:0]       wdat_q, wdat_d;
  logic               rw_q, rw_d;
  logic [255:0]       mem_data_q, mem_data_d;
  logic               mem_ready_q, mem_ready_d;
  logic               accept, do_write;
  logic [IDX_W-1:0]   req_idx;
  logic [255:0]       mem_q [DEPTH];

  assign req_idx = mem_req_addr[LINE_LSB +: IDX_W];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req_valid) state_d = (DELAY == 1) ? RESP : BUSY;
      BUSY:    if (cnt_q == CNT_ONE) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    accept      = (state_q == IDLE) && mem_req_valid;
    do_write    = (state_q == RESP) && rw_q;
    idx_d       = accept ? req_idx       : idx_q;
    wdat_d      = accept ? mem_req_data  : wdat_q;
    rw_d        = accept ? mem_req_rw    : rw_q;
    cnt_d       = cnt_q;
    if (accept)                 cnt_d = CNT_INIT;
    else if (state_q == BUSY)   cnt_d = cnt_q - CNT_ONE;
    mem_ready_d = (state_d == RESP);
    // Read data is loaded on entry to RESP so it is valid exactly while mem_ready is high.
    mem_data_d  = (state_d == RESP && !rw_d) ? mem_q[idx_d] : mem_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      mem_ready_q <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mem_ready_q <= mem_ready_d;
      mem_data_q  <= mem_data_d;
    end
    idx_q  <= idx_d;
    wdat_q <= wdat_d;
    rw_q   <= rw_d;
  end

  // Write commits at the end of RESP; a reset in that cycle suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && do_write) mem_q[idx_q] <= wdat_q;
  end

  assign mem_data  = mem_data_q;
  assign mem_ready = mem_ready_q;

`ifdef MEM_PROTO_CHECK_EN
  logic [31:0] addr_q, addr_d;
  logic        proto_err_q, proto_err_d;
  logic        mismatch;

  always_comb begin
    addr_d      = accept ? mem_req_addr : addr_q;
    mismatch    = (state_q == BUSY) &&
                  (!mem_req_valid || (mem_req_addr != addr_q) ||
                   (mem_req_rw != rw_q) || (mem_req_data != wdat_q));
    proto_err_d = proto_err_q | mismatch;
  end

  always_ff @(posedge clk) begin
    if (rst) proto_err_q <= 1'b0;
    else     proto_err_q <= proto_err_d;
    addr_q <= addr_d;
  end

  assign proto_err = proto_err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[31:LINE_LSB+IDX_W], mem_req_addr[LINE_LSB-1:0]};
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized check of two mem_responder instances (DELAY=100 and DELAY=1) against a line-array model.
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr [2];
  logic [255:0] wdat [2];
  logic         rw_s [2];
  logic         vld  [2];
  logic [255:0] rdat [2];
  logic         rdy  [2];
  logic         perr [2];

  int n_checks = 0;
  int n_err    = 0;

  logic [255:0] mdl     [2][1024];
  bit           known   [2][1024];
  logic [255:0] last_rd [2];
  int           dly     [2];

  always #5 clk = ~clk;

  mem_responder #(.DELAY(100), .DEPTH(1024), .LINE_LSB(5)) u_dut_slow (
    .clk(clk), .rst(rst),
    .mem_req_addr(addr[0]), .mem_req_data(wdat[0]), .mem_req_rw(rw_s[0]), .mem_req_valid(vld[0]),
    .mem_data(rdat[0]), .mem_ready(rdy[0]), .proto_err(perr[0])
  );

  mem_responder #(.DELAY(1), .DEPTH(1024), .LINE_LSB(5)) u_dut_fast (
    .clk(clk), .rst(rst),
    .mem_req_addr(addr[1]), .mem_req_data(wdat[1]), .mem_req_rw(rw_s[1]), .mem_req_valid(vld[1]),
    .mem_data(rdat[1]), .mem_ready(rdy[1]), .proto_err(perr[1])
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % 1024);
  endfunction

  // One complete request on instance d; checks latency, single-cycle ready and data.
  task automatic txn(input int d, input logic [31:0] a, input logic rw, input logic [255:0] wd);
    int n;
    int idx;
    @(negedge clk);
    vld[d] = 1'b1; addr[d] = a; rw_s[d] = rw; wdat[d] = wd;
    @(posedge clk); #1;
    n = 1;
    while (!rdy[d] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 256'(n), 256'(dly[d]));
    vld[d] = 1'b0;
    idx = line_of(a);
    if (rw) begin
      chk("hold_on_write", rdat[d], last_rd[d]);
      mdl[d][idx]   = wd;
      known[d][idx] = 1'b1;
    end else if (known[d][idx]) begin
      chk("read_data", rdat[d], mdl[d][idx]);
      last_rd[d] = mdl[d][idx];
    end
    @(posedge clk); #1;
    chk("ready_single", 256'(rdy[d]), 256'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; vld[0] = 1'b0; vld[1] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
  endtask

  initial begin : main
    int pulses;
    int n;
    logic [255:0] prior;
    dly[0] = 100; dly[1] = 1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; addr[d] = '0; wdat[d] = '0; rw_s[d] = 1'b0; last_rd[d] = '0;
      for (int i = 0; i < 1024; i++) known[d][i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_ready_slow", 256'(rdy[0]), 256'(0));
      chk("idle_data_slow",  rdat[0], 256'(0));
      chk("idle_ready_fast", 256'(rdy[1]), 256'(0));
      chk("idle_data_fast",  rdat[1], 256'(0));
    end

    // Directed: write/read, alias and offset on the slow instance
    txn(0, 32'h0000_0040, 1'b1, {8{32'hDEADBEEF}});
    txn(0, 32'h0000_0040, 1'b0, '0);
    chk("deadbeef", rdat[0], {8{32'hDEADBEEF}});
    txn(0, 32'h0000_8040, 1'b0, '0);
    txn(0, 32'h0000_005F, 1'b0, '0);
    txn(0, 32'h0000_0100, 1'b1, rnd256());

    // Reset 50 cycles into a write to 0x100: no response, old contents survive
    prior = mdl[0][8];
    @(negedge clk);
    vld[0] = 1'b1; addr[0] = 32'h100; rw_s[0] = 1'b1; wdat[0] = rnd256();
    @(posedge clk);
    repeat (50) @(posedge clk);
    pulse_reset();
    chk("rst_data_cleared", rdat[0], 256'(0));
    pulses = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (rdy[0]) pulses++;
    end
    chk("abort_no_ready", 256'(pulses), 256'(0));
    txn(0, 32'h0000_0100, 1'b0, '0);
    chk("abort_prior_data", rdat[0], prior);

    // Fast instance: fill lines 0..15, then back-to-back reads with valid held
    for (int i = 0; i < 16; i++) txn(1, 32'(i) << 5, 1'b1, rnd256());
    @(negedge clk);
    vld[1] = 1'b1; addr[1] = 32'h0000_0060; rw_s[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("b2b_ready", 256'(rdy[1]), 256'((i % 2) == 0));
      if (rdy[1]) chk("b2b_data", rdat[1], mdl[1][3]);
    end
    vld[1] = 1'b0;
    last_rd[1] = mdl[1][3];
    @(posedge clk);

    for (int t = 0; t < 300; t++)
      txn(1, ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), rnd256());
    for (int t = 0; t < 4; t++)
      txn(0, ($urandom & 32'hFFFF_0000) | 32'h40 | 32'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), rnd256());

    // Inputs change mid-request: response still uses the captured line
    @(negedge clk);
    vld[0] = 1'b1; addr[0] = 32'h0000_0040; rw_s[0] = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); addr[0] = 32'h0000_0200; wdat[0] = rnd256();
    @(posedge clk); #1;
`ifdef MEM_PROTO_CHECK_EN
    chk("proto_set", 256'(perr[0]), 256'(1));
`else
    chk("proto_off", 256'(perr[0]), 256'(0));
`endif
    n = 0;
    while (!rdy[0] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midbusy_ready_seen", 256'(rdy[0]), 256'(1));
    chk("midbusy_data", rdat[0], mdl[0][2]);
`ifdef MEM_PROTO_CHECK_EN
    chk("proto_sticky", 256'(perr[0]), 256'(1));
`else
    chk("proto_off_late", 256'(perr[0]), 256'(0));
`endif
    vld[0] = 1'b0;
    chk("proto_fast", 256'(perr[1]), 256'(0));
    pulse_reset();
    @(posedge clk); #1;
    chk("proto_cleared", 256'(perr[0]), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
